// File: rtl/dl_arb_mux2_if.sv
// Handshake bundle for the two-requester packet arbiter: two input streams,
// one registered output stream, and the lock status.
interface dl_arb_mux2_if #(
  parameter int NUM_BITS = 32
);
  logic                in0_valid;
  logic [NUM_BITS-1:0] in0_data;
  logic                in0_last;
  logic                in0_ready;
  logic                in1_valid;
  logic [NUM_BITS-1:0] in1_data;
  logic                in1_last;
  logic                in1_ready;
  logic                out_valid;
  logic [NUM_BITS-1:0] out_data;
  logic                out_last;
  logic                out_src;
  logic                out_ready;
  logic                busy;

  modport slave (
    input  in0_valid, in0_data, in0_last,
    output in0_ready,
    input  in1_valid, in1_data, in1_last,
    output in1_ready,
    output out_valid, out_data, out_last, out_src,
    input  out_ready,
    output busy
  );

  modport master (
    output in0_valid, in0_data, in0_last,
    input  in0_ready,
    output in1_valid, in1_data, in1_last,
    input  in1_ready,
    input  out_valid, out_data, out_last, out_src,
    output out_ready,
    input  busy
  );
endinterface

// File: rtl/dl_arb_mux2.sv
// Round-robin packet arbiter: two valid/ready requesters share one 2:1 mux
// feeding a single output register; a granted requester holds the path to its last beat.
module dl_arb_mux2 #(
  parameter int NUM_BITS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  dl_arb_mux2_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  state_t              state, state_d;
  logic                prio, prio_d;
  logic                load, g0, g1, sel, accept;
  logic [NUM_BITS-1:0] sel_data;
  logic                sel_last;
  logic                out_valid, out_last, out_src;
  logic [NUM_BITS-1:0] out_data;

  assign load = !out_valid | bus.out_ready;

  // Grants: IDLE arbitrates on prio; a lock admits only its owner, even when idle.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (state)
      LOCK0:   g0 = bus.in0_valid;
      LOCK1:   g1 = bus.in1_valid;
      default: begin
        g0 = bus.in0_valid & (!bus.in1_valid | !prio);
        g1 = bus.in1_valid & (!bus.in0_valid | prio);
      end
    endcase
  end

  // Select follows the grant; with no grant it parks on the owner or on prio.
  always_comb begin
    if (g1)                  sel = 1'b1;
    else if (g0)             sel = 1'b0;
    else if (state == LOCK1) sel = 1'b1;
    else if (state == LOCK0) sel = 1'b0;
    else                     sel = prio;
  end

  assign sel_data = sel ? bus.in1_data : bus.in0_data;
  assign sel_last = sel ? bus.in1_last : bus.in0_last;
  assign accept   = rst_n & load & (g0 | g1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_d;
      prio  <= prio_d;
    end
  end

  // Next state: lock on a non-last beat, release and hand priority over on last.
  always_comb begin
    state_d = state;
    prio_d  = prio;
    if (accept) begin
      if (sel_last) begin
        state_d = IDLE;
        prio_d  = !sel;
      end else begin
        state_d = sel ? LOCK1 : LOCK0;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.in0_ready = 1'b0;
    bus.in1_ready = 1'b0;
    bus.busy      = 1'b0;
    if (rst_n) begin
      bus.in0_ready = load & g0;
      bus.in1_ready = load & g1;
    end
    bus.busy = (state != IDLE);
  end

  // Output register; drain and reload on the same edge keeps out_valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_src   <= sel;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;
  assign bus.out_src   = out_src;
endmodule

// File: tb/tb_dl_arb_mux2.sv
// Directed bench for dl_arb_mux2 with hand-computed expectations.
module tb_dl_arb_mux2;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  dl_arb_mux2_if #(.NUM_BITS(32)) bus ();
  dl_arb_mux2 #(.NUM_BITS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] d0, input logic l0,
                       input logic v1, input logic [31:0] d1, input logic l1);
    bus.in0_valid = v0; bus.in0_data = d0; bus.in0_last = l0;
    bus.in1_valid = v1; bus.in1_data = d1; bus.in1_last = l1;
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    #1;
    chk({tag, "_rdy0"}, {31'd0, bus.in0_ready}, {31'd0, r0});
    chk({tag, "_rdy1"}, {31'd0, bus.in1_ready}, {31'd0, r1});
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                         input logic l, input logic s, input logic b);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({tag, "_data"},  bus.out_data, d);
    chk({tag, "_last"},  {31'd0, bus.out_last}, {31'd0, l});
    chk({tag, "_src"},   {31'd0, bus.out_src}, {31'd0, s});
    chk({tag, "_busy"},  {31'd0, bus.busy}, {31'd0, b});
  endtask

  initial begin
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
    chk_rdy("reset", 1'b0, 1'b0);
    tick(); tick();
    chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Single beat from requester 0
    rst_n = 1'b1;
    drive(1'b1, 32'hA5, 1'b1, 1'b0, 32'h0, 1'b0);
    chk_rdy("single", 1'b1, 1'b0);
    tick();
    chk_out("single", 1'b1, 32'hA5, 1'b1, 1'b0, 1'b0);

    // Both valid, single-beat packets: prio is now 1, so 1,0,1,0 back to back
    drive(1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 1'b1);
    for (int i = 0; i < 4; i++) begin
      automatic logic s = (i % 2 == 0);
      chk_rdy($sformatf("rr%0d", i), !s, s);
      tick();
      chk_out($sformatf("rr%0d", i), 1'b1, s ? 32'h20 : 32'h10, 1'b1, s, 1'b0);
    end

    // prio is 1; one lone beat from requester 1 hands priority back to 0
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h30, 1'b1);
    chk_rdy("solo1", 1'b0, 1'b1);
    tick();
    chk_out("solo1", 1'b1, 32'h30, 1'b1, 1'b1, 1'b0);

    // 3-beat packet from requester 0 with requester 1 waiting throughout
    drive(1'b1, 32'h1, 1'b0, 1'b1, 32'h77, 1'b1);
    chk_rdy("pkt_b1", 1'b1, 1'b0);
    tick();
    chk_out("pkt_b1", 1'b1, 32'h1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h2, 1'b0, 1'b1, 32'h77, 1'b1);
    chk_rdy("pkt_b2", 1'b1, 1'b0);
    tick();
    chk_out("pkt_b2", 1'b1, 32'h2, 1'b0, 1'b0, 1'b1);

    // Owner goes idle mid-packet: requester 1 must stay blocked
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h77, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk_rdy($sformatf("gap%0d", i), 1'b0, 1'b0);
      tick();
      chk_out($sformatf("gap%0d", i), 1'b0, 32'h2, 1'b0, 1'b0, 1'b1);
    end

    drive(1'b1, 32'h3, 1'b1, 1'b1, 32'h77, 1'b1);
    chk_rdy("pkt_b3", 1'b1, 1'b0);
    tick();
    chk_out("pkt_b3", 1'b1, 32'h3, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h77, 1'b1);
    chk_rdy("after_pkt", 1'b0, 1'b1);
    tick();
    chk_out("after_pkt", 1'b1, 32'h77, 1'b1, 1'b1, 1'b0);

    // Backpressure: prio is 0
    drive(1'b1, 32'h55, 1'b1, 1'b0, 32'h0, 1'b0);
    chk_rdy("bp_load", 1'b1, 1'b0);
    tick();
    chk_out("bp_load", 1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h66, 1'b1, 1'b1, 32'h88, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk_rdy($sformatf("bp%0d", i), 1'b0, 1'b0);
      tick();
      chk_out($sformatf("bp%0d", i), 1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    end
    bus.out_ready = 1'b1;
    chk_rdy("bp_rel1", 1'b0, 1'b1);
    tick();
    chk_out("bp_rel1", 1'b1, 32'h88, 1'b1, 1'b1, 1'b0);
    chk_rdy("bp_rel0", 1'b1, 1'b0);
    tick();
    chk_out("bp_rel0", 1'b1, 32'h66, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_rdy("drain", 1'b0, 1'b0);
    tick();
    chk_out("drain", 1'b0, 32'h66, 1'b1, 1'b0, 1'b0);

    // Reset while requester 1 holds a lock (prio is 1 here)
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h91, 1'b0);
    chk_rdy("lock1", 1'b0, 1'b1);
    tick();
    chk_out("lock1", 1'b1, 32'h91, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    chk_rdy("mid_rst", 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    chk_out("mid_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB0, 1'b1, 1'b1, 32'hB1, 1'b1);
    chk_rdy("post_rst0", 1'b1, 1'b0);
    tick();
    chk_out("post_rst0", 1'b1, 32'hB0, 1'b1, 1'b0, 1'b0);
    chk_rdy("post_rst1", 1'b0, 1'b1);
    tick();
    chk_out("post_rst1", 1'b1, 32'hB1, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dl_arb_mux2.md
# dl_arb_mux2

Two-input packet arbiter that shares the `dl_mux2` datapath between two valid/ready requesters and drives a single registered output stream. It holds a round-robin priority bit and a packet lock state machine, and generates the mux select from them. A granted requester keeps the path until it has transferred its `last` beat. It sits in front of any shared single-port resource, such as a memory or a writeback bus, that two producers must use.

## Interface
- `NUM_BITS`, 32, payload width per beat.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous reset, active-low.
- `in0_valid`  input  1  requester 0 has a beat.
- `in0_data`  input  NUM_BITS  requester 0 payload.
- `in0_last`  input  1  beat is final beat of requester 0's packet.
- `in0_ready`  output  1  requester 0 beat accepted this cycle.
- `in1_valid`, `in1_data`, `in1_last`, `in1_ready`: same as requester 0, for requester 1.
- `out_valid`  output  1  registered output beat present.
- `out_data`  output  NUM_BITS  registered payload.
- `out_last`  output  1  registered last flag.
- `out_src`  output  1  requester index the held beat came from.
- `out_ready`  input  1  downstream accepts held beat.
- `busy`  output  1  a packet lock is active (state is not IDLE).

## Operation
- Handshake: a beat transfers on any edge where valid and ready are both 1. Valid, data and last hold stable until the transfer. Ready may depend combinationally on valid.
- `load = !out_valid | out_ready`: the output register can take a new beat.
- Priority bit `prio`, reset 0. When both requesters are valid in IDLE, requester `prio` wins.
- State machine states:
  - IDLE, no lock.
  - LOCK0, requester 0 owns the path.
  - LOCK1, requester 1 owns the path.
- Grant in IDLE:
  - `g0 = in0_valid & (!in1_valid | !prio)`.
  - `g1 = in1_valid & (!in0_valid | prio)`.
- Grant in LOCKn: `gn = inn_valid`, and the other grant is 0. The other requester is never granted mid-packet, even if the owner is idle.
- Ready outputs: `in0_ready = load & g0`; `in1_ready = load & g1`. At most one is 1.
- The mux select equals the granted index. In IDLE with no grant, select is `prio`, and no ready is asserted.
- On an accepted beat from requester n:
  - `out_data` is loaded from `inn_data`, `out_last` from `inn_last`, and `out_src` with n.
  - `out_valid` is set to 1.
  - If `last` = 1: state goes to IDLE and `prio` is set to !n.
  - If `last` = 0: state goes to LOCKn and `prio` is unchanged.
  - A single-beat packet (`last` = 1 on the first beat) never leaves IDLE.
- On `out_ready & out_valid` with no new beat accepted, `out_valid` clears to 0. The data registers hold their value.
- Simultaneous output drain and input accept: the register reloads and `out_valid` stays 1. This gives full throughput, one beat per cycle.
- `busy = (state != IDLE)`.
- Reset mid-packet: the lock is abandoned, and state, priority and outputs return to their reset values. The requester must restart its packet.

## Timing
- Reset values:
  - `out_valid` 0, `out_data` 0, `out_last` 0, `out_src` 0.
  - `busy` 0, state IDLE, `prio` 0.
  - Both readies are 0 while `rst_n` = 0.
- Latency: an input beat accepted at edge k is presented on the output from edge k onward, so `out_valid` is 1 in cycle k+1.
- Throughput: 1 beat/cycle while `out_ready` = 1. With `out_ready` = 0 and `out_valid` = 1, both readies are 0.
- Priority changes only at the edge where a `last` beat is accepted. The lock state updates on the same edge.
- The block is starvation-free: with both requesters continuously valid, packets alternate 0,1,0,1…

## Test plan
- Reset, then `in0_valid`=1, `data`=0xA5, `last`=1, `out_ready`=1 -> `in0_ready`=1 in that cycle. Next cycle: `out_valid`=1, `out_data`=0xA5, `out_src`=0, `busy`=0, and `prio` becomes 1.
- Both requesters valid with single-beat packets continuously, `out_ready`=1 -> `out_src` sequence 0,1,0,1 with no bubbles, and each `inn_ready` is asserted every other cycle.
- Requester 0 sends a 3-beat packet (0x1,0x2,0x3, `last` on 0x3) while requester 1 is valid throughout -> output shows 0x1,0x2,0x3 from source 0, then requester 1's beat. `busy`=1 during beats 2–3.
- Mid-packet, `in0_valid` drops for 2 cycles while `in1_valid`=1 -> `in1_ready` stays 0 and state stays LOCK0. The packet resumes when `in0_valid` returns.
- Backpressure: `out_ready`=0 for 4 cycles with `out_valid`=1 -> `out_data` is stable, both readies are 0, and no beat is lost or duplicated after `out_ready` rises.
- `rst_n`=0 for one cycle in LOCK1 -> the next cycle shows state IDLE, `busy`=0, `out_valid`=0, `prio`=0. With both requesters valid, requester 0 is granted first.
